cheri_tbre_mem_port: RTL

Memory-side responder for the TBRE LSU request interface. It accepts TBRE capability-load and tag-clearing store requests, then runs them as 32-bit data-bus beats on a non-buffered memory port. It arbitrates against the core LSU with a bounded-deferral rule and returns `req_done`/`addr_incr`/response signalling in the form the TBRE engine expects. It sits between the TBRE engine and the data-bus mux in front of data memory.

---
 rtl/cheri_tbre_mem_port.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cheri_tbre_mem_port.sv
// TBRE LSU request responder: runs TBRE word/capability accesses as 32-bit beats on the data bus.
// Optional CHERI_TBRE_PORT_ERR_SKIP_EN: a beat-0 error on a capability load skips beat 1.
module cheri_tbre_mem_port #(
    parameter int unsigned DeferMax = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tbre_lsu_req_i,
    input  logic        tbre_lsu_is_cap_i,
    input  logic        tbre_lsu_we_i,
    input  logic [31:0] tbre_lsu_addr_i,
    input  logic [32:0] tbre_lsu_wdata_i,
    output logic        lsu_tbre_req_done_o,
    output logic        lsu_tbre_addr_incr_o,
    output logic        lsu_tbre_resp_valid_o,
    output logic        lsu_tbre_resp_err_o,
    output logic        lsu_tbre_resp_is_wr_o,
    output logic [32:0] lsu_tbre_raw_lsw_o,
    input  logic        core_req_i,
    output logic        core_hold_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [32:0] data_wdata_o,
    input  logic [32:0] data_rdata_i
);
    localparam int unsigned CntW = (DeferMax < 2) ? 1 : $clog2(DeferMax + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DeferMax);

    typedef enum logic [2:0] {
        StIdle,
        StB0Req,
        StB0Wait,
        StB1Req,
        StB1Wait,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [29:0]     addr_q, addr_d;
    logic            is_cap_q, is_cap_d;
    logic            we_q, we_d;
    logic [32:0]     wdata_q, wdata_d;
    logic [32:0]     lsw_q, lsw_d;
    logic            err_q, err_d;
    logic [CntW-1:0] defer_cnt_q, defer_cnt_d;

    logic        accept;
    logic        two_beat;
    logic        req_done;
    logic        addr_incr;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^tbre_lsu_addr_i[1:0];

    // Only a capability load needs the second beat; a store is always a single word.
    assign two_beat = is_cap_q & ~we_q;
    assign accept   = (state_q == StIdle) & tbre_lsu_req_i &
                      (~core_req_i | (defer_cnt_q == CntMax));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        is_cap_d  = is_cap_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        lsw_d     = lsw_q;
        err_d     = err_q;
        req_done  = 1'b0;
        addr_incr = 1'b0;
        bus_req   = 1'b0;
        bus_addr  = {addr_q, 2'b00};

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d   = tbre_lsu_addr_i[31:2];
                    is_cap_d = tbre_lsu_is_cap_i;
                    we_d     = tbre_lsu_we_i;
                    wdata_d  = tbre_lsu_wdata_i;
                    lsw_d    = '0;
                    err_d    = 1'b0;
                    state_d  = StB0Req;
                end
            end
            StB0Req: begin
                bus_req = 1'b1;
                if (data_gnt_i) begin
                    req_done = ~two_beat;
                    state_d  = StB0Wait;
                end
            end
            StB0Wait: begin
                if (data_rvalid_i) begin
                    if (!we_q) begin
                        lsw_d = data_rdata_i;
                    end
                    err_d = err_q | data_err_i;
                    if (two_beat) begin
`ifdef CHERI_TBRE_PORT_ERR_SKIP_EN
                        if (data_err_i) begin
                            req_done = 1'b1;
                            state_d  = StResp;
                        end else begin
                            state_d = StB1Req;
                        end
`else
                        state_d = StB1Req;
`endif
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StB1Req: begin
                bus_req   = 1'b1;
                addr_incr = 1'b1;
                bus_addr  = {addr_q, 2'b00} + 32'd4;
                if (data_gnt_i) begin
                    req_done = 1'b1;
                    state_d  = StB1Wait;
                end
            end
            StB1Wait: begin
                if (data_rvalid_i) begin
                    err_d   = err_q | data_err_i;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        defer_cnt_d = defer_cnt_q;
        if (!tbre_lsu_req_i || accept) begin
            defer_cnt_d = '0;
        end else if ((state_q == StIdle) && core_req_i && (defer_cnt_q != CntMax)) begin
            defer_cnt_d = defer_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            is_cap_q    <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            lsw_q       <= '0;
            err_q       <= 1'b0;
            defer_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            is_cap_q    <= is_cap_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            lsw_q       <= lsw_d;
            err_q       <= err_d;
            defer_cnt_q <= defer_cnt_d;
        end
    end

    assign lsu_tbre_req_done_o   = req_done;
    assign lsu_tbre_addr_incr_o  = addr_incr;
    assign lsu_tbre_resp_valid_o = (state_q == StResp);
    assign lsu_tbre_resp_err_o   = (state_q == StResp) & err_q;
    assign lsu_tbre_resp_is_wr_o = we_q;
    assign lsu_tbre_raw_lsw_o    = lsw_q;
    assign core_hold_o           = (state_q != StIdle) | accept;
    assign data_req_o            = bus_req;
    assign data_we_o             = we_q;
    assign data_be_o             = bus_req ? 4'hF : 4'h0;
    assign data_addr_o           = bus_req ? bus_addr : 32'h0;
    assign data_wdata_o          = we_q ? wdata_q : 33'h0;

endmodule
